// File: rtl/ooo_rel_buf_pkg.sv
// ooo_rel_buf_pkg: shared entry and release-classification types for the out-of-order release buffer.
// Contents:
//   MAX_DWIDTH   widest payload an entry can hold; instances use the low DWIDTH bits
//   entry_t      one buffer slot: occupied flag, released flag, payload
//   rel_kind_t   outcome of a release request against one entry
//   classify_rel maps (request, occupied, released) onto rel_kind_t
package ooo_rel_buf_pkg;

    localparam int MAX_DWIDTH = 32;

    typedef logic [MAX_DWIDTH-1:0] data_t;

    typedef struct packed {
        logic  occupied;
        logic  released;
        data_t data;
    } entry_t;

    typedef enum logic [1:0] {
        REL_NONE,
        REL_SET,
        REL_DUP,
        REL_ILLEGAL
    } rel_kind_t;

    // An unoccupied target is illegal; a repeated release is harmless.
    function automatic rel_kind_t classify_rel(input logic valid, input logic occupied,
                                               input logic released);
        return !valid ? REL_NONE : !occupied ? REL_ILLEGAL : released ? REL_DUP : REL_SET;
    endfunction

endpackage

// File: rtl/ooo_rel_buf_pri_enc.sv
// ooo_rel_buf_pri_enc: lowest-set-bit encoder with an any-set flag.
// Ports:
//   req  in   N  request vector
//   idx  out  W  index of the lowest set bit (0 when none set)
//   any  out  1  at least one bit of req is set
module ooo_rel_buf_pri_enc #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scanning downward lets the lowest set bit win.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ooo_rel_buf.sv
// ooo_rel_buf: buffer whose entries are allocated in order but drained only after an explicit release.
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   in_valid/in_ready     push handshake, in_data stored into entry in_idx
//   rel_valid, rel_idx    mark an occupied entry as releasable
//   out_valid/out_ready   pop handshake for the lowest released entry out_idx / out_data
//   count                 number of occupied entries
//   err                   sticky: a release hit an unoccupied entry
module ooo_rel_buf
    import ooo_rel_buf_pkg::*;
#(
    parameter int DWIDTH = 4,
    parameter int DEPTH  = 4,
    parameter int IW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic [IW-1:0]     in_idx,
    input  logic              rel_valid,
    input  logic [IW-1:0]     rel_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [IW-1:0]     out_idx,
    output logic [IW:0]       count,
    output logic              err
);

    entry_t           ent [DEPTH];
    logic [DEPTH-1:0] occ_vec;
    logic [DEPTH-1:0] elig_vec;
    logic             push;
    logic             pop;
    logic             err_q;
    rel_kind_t        rel_kind;

    always_comb begin
        occ_vec  = '0;
        elig_vec = '0;
        count    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_vec[i]  = ent[i].occupied;
            elig_vec[i] = ent[i].occupied & ent[i].released;
            count       = count + (IW+1)'(ent[i].occupied);
        end
    end

    ooo_rel_buf_pri_enc #(.N(DEPTH), .W(IW)) u_free_enc (
        .req (~occ_vec),
        .idx (in_idx),
        .any (in_ready)
    );

    ooo_rel_buf_pri_enc #(.N(DEPTH), .W(IW)) u_out_enc (
        .req (elig_vec),
        .idx (out_idx),
        .any (out_valid)
    );

    assign out_data = out_valid ? ent[out_idx].data[DWIDTH-1:0] : '0;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign err      = err_q;

    // Looked up on registered state, so a same-cycle push target still reads as unoccupied.
    assign rel_kind = classify_rel(rel_valid, ent[rel_idx].occupied, ent[rel_idx].released);

    // Push only targets free entries and pop only released ones, so the three
    // operations never compete for the same entry except release-vs-pop, where
    // the release is necessarily a repeat and the pop wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            err_q <= 1'b0;
        end else begin
            if (rel_kind == REL_ILLEGAL) err_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (push && in_idx == IW'(i)) begin
                    ent[i].occupied <= 1'b1;
                    ent[i].released <= 1'b0;
                    ent[i].data     <= MAX_DWIDTH'(in_data);
                end else if (pop && out_idx == IW'(i)) begin
                    ent[i].occupied <= 1'b0;
                    ent[i].released <= 1'b0;
                end else if (rel_kind == REL_SET && rel_idx == IW'(i)) begin
                    ent[i].released <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ooo_rel_buf.sv
// tb_ooo_rel_buf: directed and randomized self-checking bench for ooo_rel_buf.
module tb_ooo_rel_buf;

    localparam int DW = 4;
    localparam int DP = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          rel_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [IW-1:0] rel_idx = '0;
    logic          in_ready, out_valid, err;
    logic [IW-1:0] in_idx, out_idx;
    logic [DW-1:0] out_data;
    logic [IW:0]   count;

    int checks = 0;
    int errors = 0;

    logic          m_occ [DP];
    logic          m_rel [DP];
    logic [DW-1:0] m_dat [DP];
    logic          m_err;
    int            pend [16];

    always #5 clk = ~clk;

    ooo_rel_buf #(.DWIDTH(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_idx    (in_idx),
        .rel_valid (rel_valid),
        .rel_idx   (rel_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .count     (count),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DP; i++) begin
            m_occ[i] = 1'b0;
            m_rel[i] = 1'b0;
            m_dat[i] = '0;
        end
        m_err = 1'b0;
        for (int i = 0; i < 16; i++) pend[i] = 0;
    endtask

    // One cycle against the reference model: check outputs, drive, score, advance.
    task automatic rnd_cycle(input logic iv, input logic [DW-1:0] id, input logic rv,
                             input logic [IW-1:0] ri, input logic ordy);
        int fi, ei, cnt;
        logic do_push, do_pop;
        fi = -1; ei = -1; cnt = 0;
        for (int i = DP - 1; i >= 0; i--) begin
            if (!m_occ[i]) fi = i;
            if (m_occ[i] && m_rel[i]) ei = i;
            if (m_occ[i]) cnt++;
        end
        check("rnd_in_ready", in_ready, fi >= 0);
        check("rnd_in_idx", in_idx, fi >= 0 ? fi : 0);
        check("rnd_out_valid", out_valid, ei >= 0);
        check("rnd_out_idx", out_idx, ei >= 0 ? ei : 0);
        check("rnd_out_data", out_data, ei >= 0 ? m_dat[ei] : 0);
        check("rnd_count", count, cnt);
        check("rnd_err", err, m_err);
        in_valid  = iv;
        in_data   = id;
        rel_valid = rv;
        rel_idx   = ri;
        out_ready = ordy;
        do_push = iv && fi >= 0;
        do_pop  = ordy && ei >= 0;
        if (do_pop) begin
            check("sb_known_data", pend[out_data] > 0, 1);
            if (pend[out_data] > 0) pend[out_data]--;
        end
        if (do_push) pend[id]++;
        if (rv) begin
            if (!m_occ[ri]) m_err = 1'b1;
            else m_rel[ri] = 1'b1;
        end
        if (do_pop) begin
            m_occ[ei] = 1'b0;
            m_rel[ei] = 1'b0;
        end
        if (do_push) begin
            m_occ[fi] = 1'b1;
            m_rel[fi] = 1'b0;
            m_dat[fi] = id;
        end
        step();
    endtask

    initial begin
        logic [DW-1:0] fill [4] = '{4'h3, 4'h5, 4'h7, 4'h9};
        int total;

        // Reset values
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_in_idx", in_idx, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_data", out_data, 0);
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        rstn = 1'b1;
        step();

        // Illegal release from empty
        rel_valid = 1'b1; rel_idx = 2'd1;
        step();
        rel_valid = 1'b0;
        check("illegal_err", err, 1);
        check("illegal_count", count, 0);
        check("illegal_out_valid", out_valid, 0);
        step();
        check("illegal_err_sticky", err, 1);

        // Fill
        for (int k = 0; k < 4; k++) begin
            check("fill_in_idx", in_idx, k);
            in_valid = 1'b1; in_data = fill[k];
            step();
        end
        check("fill_count", count, 4);
        check("fill_in_ready", in_ready, 0);
        check("fill_in_idx_full", in_idx, 0);
        in_data = 4'hA;
        step();
        in_valid = 1'b0;
        check("fill_drop_count", count, 4);
        check("fill_no_out", out_valid, 0);

        // Out-of-order release and pop
        rel_valid = 1'b1; rel_idx = 2'd2;
        step();
        check("ooo_out_idx2", out_idx, 2);
        check("ooo_out_data7", out_data, 4'h7);
        rel_idx = 2'd0;
        step();
        rel_valid = 1'b0;
        check("ooo_out_idx0", out_idx, 0);
        check("ooo_out_data3", out_data, 4'h3);
        out_ready = 1'b1;
        step();
        check("ooo_second_idx", out_idx, 2);
        check("ooo_second_data", out_data, 4'h7);
        check("ooo_count3", count, 3);
        step();
        out_ready = 1'b0;
        check("ooo_count2", count, 2);
        check("ooo_empty_out", out_valid, 0);

        // Refill, then pop and push in the same cycle while full
        check("sim_in_idx0", in_idx, 0);
        in_valid = 1'b1; in_data = 4'hB;
        step();
        check("sim_in_idx2", in_idx, 2);
        in_data = 4'hD;
        step();
        in_valid = 1'b0;
        check("sim_full_count", count, 4);
        rel_valid = 1'b1; rel_idx = 2'd1;
        step();
        rel_valid = 1'b0;
        check("sim_out_idx1", out_idx, 1);
        check("sim_out_data5", out_data, 4'h5);
        in_valid = 1'b1; in_data = 4'hC; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("sim_count3", count, 3);
        check("sim_in_ready", in_ready, 1);
        check("sim_in_idx1", in_idx, 1);
        check("sim_out_valid", out_valid, 0);

        // Reset mid-stream
        rel_valid = 1'b1; rel_idx = 2'd0;
        step();
        rel_valid = 1'b0;
        check("mid_pre_out_valid", out_valid, 1);
        check("mid_pre_out_data", out_data, 4'hB);
        rstn = 1'b0;
        #1;
        check("mid_count", count, 0);
        check("mid_out_valid", out_valid, 0);
        check("mid_err", err, 0);
        check("mid_in_ready", in_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        model_clear();
        step();

        // Randomized traffic against the model and scoreboard
        for (int n = 0; n < 400; n++) begin
            rnd_cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 3) != 0),
                      IW'($urandom_range(0, DP - 1)), 1'($urandom_range(0, 2) != 0));
        end
        for (int k = 0; k < DP; k++) rnd_cycle(1'b0, '0, m_occ[k], IW'(k), 1'b1);
        for (int k = 0; k < DP + 1; k++) rnd_cycle(1'b0, '0, 1'b0, '0, 1'b1);
        total = 0;
        for (int i = 0; i < 16; i++) total += pend[i];
        check("sb_all_drained", total, 0);
        check("sb_final_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ooo_rel_buf.md
OOO_REL_BUF -- requirements
Module: ooo_rel_buf

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 4, payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, number of entries (power of two, >=2).
REQ-003 The block SHALL have parameter IW = $clog2(DEPTH), entry index width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  producer offers in_data.
REQ-007 in_ready  output  1  at least one free entry exists.
REQ-008 in_data  input  DWIDTH  payload to store.
REQ-009 in_idx  output  IW  entry the current push is written into.
REQ-010 rel_valid  input  1  release request.
REQ-011 rel_idx  input  IW  entry to release.
REQ-012 out_valid  output  1  at least one occupied and released entry exists.
REQ-013 out_ready  input  1  consumer accepts out_data.
REQ-014 out_data  output  DWIDTH  payload of the selected entry.
REQ-015 out_idx  output  IW  entry currently selected for output.
REQ-016 count  output  IW+1  number of occupied entries.
REQ-017 err  output  1  sticky flag: illegal release seen.

Function
REQ-018 Each entry SHALL hold an occupied bit, a released bit and DWIDTH data.
REQ-019 in_ready, in_idx, out_valid, out_idx, out_data and count SHALL be combinational from registered state only, with no combinational path from any input.
REQ-020 in_idx SHALL be the lowest-index free entry; it is 0 when the buffer is full.
REQ-021 A push (in_valid && in_ready) SHALL set occupied=1, released=0 and data=in_data in entry in_idx at the next edge.
REQ-022 in_valid while in_ready=0 SHALL be ignored, with no state change.
REQ-023 A release (rel_valid) of an occupied, unreleased entry SHALL set its released bit at the next edge.
REQ-024 A release of an already released entry SHALL be a no-op with no error.
REQ-025 A release of an unoccupied entry SHALL be ignored and SHALL set err at the next edge.
REQ-026 A release targeting the entry being pushed in the same cycle SHALL count as unoccupied (REQ-025).
REQ-027 out_idx SHALL be the lowest-index entry with occupied && released; out_data SHALL be that entry's data.
REQ-028 When no entry is eligible, out_idx and out_data SHALL be 0.
REQ-029 A pop (out_valid && out_ready) SHALL clear occupied and released of out_idx at the next edge.
REQ-030 An entry freed by a pop SHALL NOT be allocatable in the same cycle; it is reusable from the next cycle.
REQ-031 Push, release and pop in one cycle SHALL all take effect independently.
REQ-032 count SHALL change by +1 for a push only, -1 for a pop only, and 0 for both or neither.
REQ-033 Minimum latency SHALL be: push at cycle N; release possible at N+1; out_valid at N+2.
REQ-034 Stored data SHALL be neither altered nor duplicated; each push yields exactly one pop.

Reset
REQ-035 Reset SHALL clear all occupied and released bits and err.
REQ-036 During reset, outputs SHALL be in_ready=1, in_idx=0, out_valid=0, out_idx=0, out_data=0, count=0, err=0.
REQ-037 Data storage need not be reset.
REQ-038 Reset asserted mid-operation SHALL discard all entries immediately, without draining.

Structure
REQ-039 A shared package ooo_rel_buf_pkg SHALL hold the entry struct type (occupied, released, data) and index helper types.
REQ-040 A single sub-module ooo_rel_buf_pri_enc (lowest-set-bit encoder with any-set flag) SHALL be instantiated twice: once for free-entry selection, once for output selection.

Verification
REQ-041 Fill: push 0x3,0x5,0x7,0x9 on consecutive cycles -> in_idx 0,1,2,3; count=4; in_ready=0; a 5th push of 0xA is dropped.
REQ-042 Out-of-order: after REQ-041, release idx2 then idx0 -> out_data 0x3 (idx0) popped first, then 0x7 (idx2); count=2.
REQ-043 Illegal release: from reset, rel_valid with rel_idx=1 -> err=1 next cycle and stays 1; entries unchanged.
REQ-044 Simultaneous: full buffer with idx1 released; pop idx1 and push 0xC in the same cycle -> push ignored (in_ready=0); next cycle in_ready=1, in_idx=1.
REQ-045 Reset mid-stream: rstn low with count=3 -> count=0 and out_valid=0 immediately.
REQ-046 Random: constrained-random push/release/pop with a data-integrity scoreboard on the in/out handshakes -> no loss, no duplication, no data created without a prior push.
